mem_bridge_sequencer: RTL

// - Upstream driver for the 32k ROM / 32k RAM main memory (Addr[15]=0 ROM, 1 RAM).
// - Accepts one read/write request at a time from the pipeline over a valid/ready handshake.
// - Sequences Addr, MEMDATA tristate, MemBridge_Load (act-low write) and MemBridge_Direction (1 = memory drives) with programmable setup/pulse/hold timing.
// - Returns read data or write completion as a single-cycle response pulse.

---
 rtl/mem_bridge_sequencer_if.sv | 45 ++++
 rtl/mem_bridge_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge_sequencer_if.sv
// Request/response channel between the pipeline and mem_bridge_sequencer.
//
// Signals:
//   req_valid  request present (pipeline -> bridge)
//   req_ready  bridge can accept; transfer on valid & ready
//   req_write  1 = write, 0 = read
//   req_addr   16-bit target address (bit 15: 0 = ROM, 1 = RAM)
//   req_wdata  write data
//   rsp_valid  one-cycle completion pulse
//   rsp_rdata  read data, valid with rsp_valid, held until the next read
//   rsp_err    with rsp_valid: write was rejected
//
// Modports: master = pipeline side, slave = bridge side.
interface mem_bridge_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/mem_bridge_sequencer.sv
// Upstream sequencer for the 32k ROM / 32k RAM main memory (Addr[15] = 0 ROM, 1 RAM).
//
// Takes one read or write at a time from the pipeline and sequences the memory bus with
// programmable setup / pulse / hold (write) and turnaround (read) timing, then returns a
// single-cycle response.
//
// Parameters (each 1..15):
//   SETUP_CYCLES  write: data/address stable before MemBridge_Load falls
//   PULSE_CYCLES  write: MemBridge_Load low width
//   HOLD_CYCLES   write: data held after MemBridge_Load rises
//   READ_CYCLES   read: MemBridge_Direction high before data capture
//
// Ports:
//   clk                  system clock, rising edge
//   reset_n              asynchronous active-low reset
//   bus                  request/response channel (mem_bridge_sequencer_if.slave)
//   Addr                 memory address, holds the last accepted address
//   MEMDATA              memory data bus; driven only during the three write states
//   MemBridge_Load       active-low RAM write strobe
//   MemBridge_Direction  1 = memory drives MEMDATA
//
// Build option:
//   MEMBRIDGE_ROM_WP_EN  when defined, writes to the ROM half are rejected without any bus
//                        activity and complete with rsp_err = 1 one cycle after accept.
//                        When undefined they are sequenced normally and rsp_err stays 0.
module mem_bridge_sequencer #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES  = 1,
    parameter int unsigned READ_CYCLES  = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    mem_bridge_sequencer_if.slave        bus,
    output logic [15:0]                  Addr,
    inout  wire  [7:0]                   MEMDATA,
    output logic                         MemBridge_Load,
    output logic                         MemBridge_Direction
);

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [3:0] SetupLoad = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] PulseLoad = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] HoldLoad  = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] ReadLoad  = 4'(READ_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWSetup,
        StWPulse,
        StWHold,
        StRDrive,
        StRTurn,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rsp_err_d, rsp_err_q;
    logic        rsp_valid_q;
    logic        ready_q;
    logic        load_q;
    logic        dir_q;
    logic        mem_oe_q;

    logic        accept;
    logic        rom_wp;

    assign accept = bus.req_valid && ready_q;

`ifdef MEMBRIDGE_ROM_WP_EN
    assign rom_wp = bus.req_write && !bus.req_addr[15];
`else
    assign rom_wp = 1'b0;
`endif

    // Next-state logic. Every phase reloads the counter on entry and leaves when it hits 0.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rsp_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (rom_wp) begin
                        state_d   = StResp;
                        rsp_err_d = 1'b1;
                    end else if (bus.req_write) begin
                        state_d = StWSetup;
                        cnt_d   = SetupLoad;
                    end else begin
                        state_d = StRDrive;
                        cnt_d   = ReadLoad;
                    end
                end
            end
            StWSetup: begin
                if (cnt_q == 4'd0) begin
                    state_d = StWPulse;
                    cnt_d   = PulseLoad;
                end
            end
            StWPulse: begin
                if (cnt_q == 4'd0) begin
                    state_d = StWHold;
                    cnt_d   = HoldLoad;
                end
            end
            StWHold: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end
            end
            StRDrive: begin
                // Memory has driven the bus for READ_CYCLES by the end of the last cycle.
                if (cnt_q == 4'd0) begin
                    rdata_d = MEMDATA;
                    state_d = StRTurn;
                end
            end
            StRTurn: begin
                // One idle cycle with nobody driving before the bus can be reused.
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs are decoded from the next state and registered, so strobes change only on
    // clock edges and line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            load_q      <= 1'b1;
            dir_q       <= 1'b0;
            mem_oe_q    <= 1'b0;
        end else begin
            ready_q     <= (state_d == StIdle);
            rsp_valid_q <= (state_d == StResp);
            rsp_err_q   <= rsp_err_d;
            load_q      <= (state_d != StWPulse);
            dir_q       <= (state_d == StRDrive);
            mem_oe_q    <= (state_d == StWSetup) || (state_d == StWPulse) ||
                           (state_d == StWHold);
        end
    end

    assign bus.req_ready       = ready_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_rdata       = rdata_q;
    assign bus.rsp_err         = rsp_err_q;
    assign Addr                = addr_q;
    assign MemBridge_Load      = load_q;
    assign MemBridge_Direction = dir_q;
    assign MEMDATA             = mem_oe_q ? wdata_q : 8'hzz;

endmodule
